// File: rtl/volt_to_dac_code.sv
// Signed BCD millivolt setpoint -> 12-bit two's-complement / offset-binary DAC code.
// Optional macro VOLT_ROUND_NEAREST_EN: round-half-up of the magnitude instead of floor.
`timescale 1ns/1ps
module volt_to_dac_code #(
  parameter int FULL_MV = 5000,
  parameter int CODE_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [19:0]       in_dec,
  input  logic [7:0]        in_sig,
  output logic              busy,
  output logic              code_valid,
  output logic [CODE_W-1:0] dac_code,
  output logic [CODE_W-1:0] dac_ob,
  output logic              clip,
  output logic              fmt_err
);

  localparam int ACC_W = 17;
  localparam int DIV_W = ACC_W + CODE_W - 1;
  localparam int R_W   = $clog2(FULL_MV);
  localparam int POS_MAX = (1 << (CODE_W - 1)) - 1;
  localparam logic [CODE_W-1:0] CODE_MSB = CODE_W'(1) << (CODE_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CONV, S_DIV, S_OUT} state_t;

  state_t            state_q;
  logic [19:0]       dec_q;
  logic [7:0]        sig_q;
  logic              err_q;
  logic              neg_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DIV_W-1:0]  dq_q;
  logic [R_W-1:0]    rem_q;
  logic [4:0]        cnt_q;
  logic              code_valid_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] ob_q;
  logic              clip_q;
  logic              fmt_err_q;

  // Handshake: a setpoint transfers on a clk edge where in_valid && in_ready;
  // in_ready is high only in IDLE (and never while rst is asserted), so
  // anything presented during a conversion is simply not taken.
  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q != S_IDLE);
  assign code_valid = code_valid_q;
  assign dac_code   = code_q;
  assign dac_ob     = ob_q;
  assign clip       = clip_q;
  assign fmt_err    = fmt_err_q;

  logic             bad_fmt;
  logic [ACC_W-1:0] acc_d;
  logic [DIV_W-1:0] dividend_d;
  logic [R_W:0]     rem_sh;
  logic [R_W:0]     rem_sub;
  logic [R_W:0]     rem_d;
  logic             q_bit;
  logic             sat;
  logic [CODE_W-1:0] res_code;

  always_comb begin
    bad_fmt = (sig_q != 8'd43) && (sig_q != 8'd45);
    for (int i = 0; i < 5; i++) begin
      if (dec_q[4*i +: 4] > 4'd9) bad_fmt = 1'b1;
    end
  end

  // dec_q shifts left during CONV so the current digit is always the top nibble.
  always_comb begin
    acc_d = acc_q * ACC_W'(10) + {{(ACC_W-4){1'b0}}, dec_q[19:16]};
`ifdef VOLT_ROUND_NEAREST_EN
    dividend_d = {acc_d, {(CODE_W-1){1'b0}}} + DIV_W'(FULL_MV / 2);
`else
    dividend_d = {acc_d, {(CODE_W-1){1'b0}}};
`endif
  end

  always_comb begin
    rem_sh  = {rem_q, dq_q[DIV_W-1]};
    rem_sub = rem_sh - (R_W+1)'(FULL_MV);
    q_bit   = (rem_sh >= (R_W+1)'(FULL_MV));
    rem_d   = q_bit ? rem_sub : rem_sh;
  end

  // Negative side reaches one code further than the positive side.
  always_comb begin
    if (!neg_q) begin
      sat      = (dq_q > DIV_W'(POS_MAX));
      res_code = sat ? ~CODE_MSB : dq_q[CODE_W-1:0];
    end else begin
      sat      = (dq_q > DIV_W'(POS_MAX + 1));
      res_code = sat ? CODE_MSB : (CODE_W'(0) - dq_q[CODE_W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dec_q        <= '0;
      sig_q        <= '0;
      err_q        <= 1'b0;
      neg_q        <= 1'b0;
      acc_q        <= '0;
      dq_q         <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      ob_q         <= CODE_MSB;
      clip_q       <= 1'b0;
      fmt_err_q    <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            dec_q   <= in_dec;
            sig_q   <= in_sig;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_q   <= bad_fmt;
          neg_q   <= (sig_q == 8'd45);
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= bad_fmt ? S_OUT : S_CONV;
        end
        S_CONV: begin
          acc_q <= acc_d;
          dec_q <= {dec_q[15:0], 4'h0};
          if (cnt_q == 5'd4) begin
            dq_q    <= dividend_d;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DIV;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DIV: begin
          dq_q  <= {dq_q[DIV_W-2:0], q_bit};
          rem_q <= R_W'(rem_d);
          if (cnt_q == 5'(DIV_W - 1)) begin
            cnt_q   <= '0;
            state_q <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_OUT: begin
          code_valid_q <= 1'b1;
          fmt_err_q    <= err_q;
          if (err_q) begin
            clip_q <= 1'b0;
          end else begin
            clip_q <= sat;
            code_q <= res_code;
            ob_q   <= res_code ^ CODE_MSB;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_volt_to_dac_code.sv
// Scoreboard bench for volt_to_dac_code: driver pushes expected results, a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_volt_to_dac_code;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] in_dec = '0;
  logic [7:0]  in_sig = '0;
  logic        in_ready, busy, code_valid, clip, fmt_err;
  logic [11:0] dac_code, dac_ob;

  volt_to_dac_code dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dec(in_dec), .in_sig(in_sig), .busy(busy), .code_valid(code_valid),
    .dac_code(dac_code), .dac_ob(dac_ob), .clip(clip), .fmt_err(fmt_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef VOLT_ROUND_NEAREST_EN
  localparam logic [11:0] P1000 = 12'h19A;
  localparam logic [11:0] N1000 = 12'hE66;
`else
  localparam logic [11:0] P1000 = 12'h199;
  localparam logic [11:0] N1000 = 12'hE67;
`endif

  int n_checks = 0;
  int n_err = 0;
  // {expected cycle[31:0], fmt_err, clip, dac_code[11:0]}
  logic [45:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [11:0] c, input logic cl, input logic fe, input int at);
    exp_q.push_back({32'(at), fe, cl, c});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && code_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_code_valid: got code %0h expected none (t=%0t)", dac_code, $time);
      end else begin
        logic [45:0] e;
        e = exp_q.pop_front();
        check("latency_cycle", 32'(cyc), e[45:14]);
        check("dac_code", 32'(dac_code), 32'(e[11:0]));
        check("dac_ob", 32'(dac_ob), 32'(e[11:0] ^ 12'h800));
        check("clip", 32'(clip), 32'(e[12]));
        check("fmt_err", 32'(fmt_err), 32'(e[13]));
      end
    end
  end

  // driver tasks
  task automatic send(input logic [19:0] d, input logic [7:0] s,
                      input logic [11:0] c, input logic cl, input logic fe);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1");
      return;
    end
    in_valid = 1'b1;
    in_dec   = d;
    in_sig   = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push(c, cl, fe, cyc + (fe ? 2 : 35));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_code_valid"}, 32'(code_valid), 32'd0);
    check({tag, "_dac_code"}, 32'(dac_code), 32'h000);
    check({tag, "_dac_ob"}, 32'(dac_ob), 32'h800);
    check({tag, "_clip"}, 32'(clip), 32'd0);
    check({tag, "_fmt_err"}, 32'(fmt_err), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_cyc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // directed vectors
    send(20'h01000, 8'd43, P1000, 1'b0, 1'b0);
    send(20'h01000, 8'd45, N1000, 1'b0, 1'b0);
    send(20'h05000, 8'd43, 12'h7FF, 1'b1, 1'b0);
    send(20'h05000, 8'd45, 12'h800, 1'b0, 1'b0);
    send(20'h09999, 8'd45, 12'h800, 1'b1, 1'b0);
    send(20'h00003, 8'd43, 12'h001, 1'b0, 1'b0);
    send(20'h00000, 8'd45, 12'h000, 1'b0, 1'b0);
    send(20'h01000, 8'd43, P1000, 1'b0, 1'b0);
    send(20'h0A000, 8'd43, P1000, 1'b0, 1'b1);
    send(20'h01000, 8'd48, P1000, 1'b0, 1'b1);
    send(20'h9F000, 8'd45, P1000, 1'b0, 1'b1);
    send(20'h02500, 8'd43, 12'h400, 1'b0, 1'b0);

    // a second setpoint during busy must be ignored
    repeat (3) @(negedge clk);
    check("busy_during_conv", 32'(busy), 32'd1);
    check("ready_during_conv", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_dec   = 20'h00003;
    in_sig   = 8'd43;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;

    send(20'h01234, 8'd45, 12'hE07, 1'b0, 1'b0);
    send(20'h04998, 8'd43, 12'h7FF, 1'b0, 1'b0);
    send(20'h99999, 8'd43, 12'h7FF, 1'b1, 1'b0);
    send(20'h00001, 8'd45, 12'h000, 1'b0, 1'b0);
    drain();

    // abort mid-conversion with reset: no result may appear
    in_valid = 1'b1;
    in_dec   = 20'h02500;
    in_sig   = 8'd45;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("abort");
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check("abort_idle_ready", 32'(in_ready), 32'd1);
    send(20'h01000, 8'd43, P1000, 1'b0, 1'b0);
    drain();

    // continuous in_valid: next acceptance directly after OUT
    @(negedge clk);
    in_valid = 1'b1;
    in_dec   = 20'h00003;
    in_sig   = 8'd43;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    push(12'h001, 1'b0, 1'b0, acc_cyc + 35);
    push(N1000, 1'b0, 1'b0, acc_cyc + 36 + 35);
    in_dec = 20'h01000;
    in_sig = 8'd45;
    repeat (36) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
